// File: rtl/mult.sv
`default_nettype none
// ============================================================================
// Module   : mult
// Purpose  : Sequential signed 32x32 radix-2 Booth multiplier for the MD path.
//            One Booth step per clock, 32 steps, 64-bit product on hi/lo.
// Revision : 1.0 - initial release
// ============================================================================
module mult (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDControl,
  input  logic [31:0] multiplicando,
  input  logic [31:0] multiplicador,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  logic [32:0] acc;       // A, one guard bit so M = -2^31 cannot overflow
  logic [32:0] mcand;     // M, sign-extended multiplicand
  logic [31:0] mplier;    // Q, shifts out toward the low product word
  logic        q_m1;      // Q(-1), previous LSB of Q
  logic [4:0]  count;     // steps already completed

  logic [32:0] sum;
  logic [32:0] acc_next;
  logic [31:0] mplier_next;
  logic        q_m1_next;

  // One Booth step: add/subtract M by the bit pair, then arithmetic shift right
  always_comb begin
    sum = acc;
    case ({mplier[0], q_m1})
      2'b10:   sum = acc - mcand;
      2'b01:   sum = acc + mcand;
      default: sum = acc;
    endcase
    acc_next    = {sum[32], sum[32:1]};
    mplier_next = {sum[0], mplier[31:1]};
    q_m1_next   = mplier[0];
  end

  // Control FSM and datapath registers; hi/lo only written on the final step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      q_m1   <= 1'b0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MDControl) begin
            acc    <= '0;
            mplier <= multiplicador;
            q_m1   <= 1'b0;
            mcand  <= {multiplicando[31], multiplicando};
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          q_m1   <= q_m1_next;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            // Lower 64 bits of {A,Q} after the last shift hold the product
            hi    <= acc_next[31:0];
            lo    <= mplier_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
